// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : ID-stage stall/flush controller for a 5-stage MIPS pipeline.
//               Tracks in-flight register writers in a shift-register scoreboard
//               and sequences RAW stalls, redirects and memory-wait freezes.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DEPTH  = 2,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr,
    input  logic [4:0]       id_wsel,
    input  logic             id_load,
    input  logic             redirect,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_en,
    output logic [1:0]       hazard,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DWAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_redir_pend;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [DEPTH-1:0] r_sb_vld;
    logic [4:0]       r_sb_wsel [DEPTH];
    // Only the EX-stage entry's load flag ever matters (load-use with forwarding).
    logic             r_sb_load0;

    logic [DEPTH-1:0] w_match;
    logic             w_raw;
    logic             w_freeze;
    logic             w_redir;
    logic             w_stall;
    logic             w_issue;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_match
            assign w_match[k] = r_sb_vld[k] && (r_sb_wsel[k] != 5'd0) &&
                                ((id_use_rs && (r_sb_wsel[k] == id_rs)) ||
                                 (id_use_rt && (r_sb_wsel[k] == id_rt)));
        end
    endgenerate

    assign w_raw    = id_valid && ((FWD_EN != 0) ? (w_match[0] && r_sb_load0) : (|w_match));
    assign w_freeze = (r_state == S_DWAIT) || (dmem_req && !dhit);
    assign w_redir  = !w_freeze && (redirect || r_redir_pend);
    assign w_stall  = !w_freeze && !w_redir && w_raw;
    assign w_issue  = !w_raw && !w_redir;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_en    = 1'b1;
        hazard     = 2'd0;
        if (w_freeze) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
            hazard  = 2'd3;
        end else if (w_redir) begin
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            hazard     = 2'd2;
        end else if (w_raw) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            hazard     = 2'd1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_RUN;
            r_redir_pend <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            case (r_state)
                S_RUN:   if (dmem_req && !dhit) r_state <= S_DWAIT;
                S_DWAIT: if (dhit)              r_state <= S_RUN;
                default:                        r_state <= S_RUN;
            endcase
            // A redirect seen while frozen is replayed on the first unfrozen cycle.
            if (w_freeze)
                r_redir_pend <= r_redir_pend || redirect;
            else
                r_redir_pend <= 1'b0;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sb_vld   <= '0;
            r_sb_load0 <= 1'b0;
            for (int k = 0; k < DEPTH; k++)
                r_sb_wsel[k] <= 5'd0;
        end else if (!w_freeze) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_sb_vld[k]  <= r_sb_vld[k-1];
                r_sb_wsel[k] <= r_sb_wsel[k-1];
            end
            r_sb_vld[0]  <= id_valid && id_wr && w_issue;
            r_sb_wsel[0] <= id_wsel;
            r_sb_load0   <= id_load;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Drives three differently parameterised scoreboards with shared
//               stimulus and checks them against an age-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic       id_wr = 1'b0, id_load = 1'b0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_wsel = 5'd0;
    logic       redirect = 1'b0, ihit = 1'b1, dmem_req = 1'b0, dhit = 1'b0;

    logic       pc_en [3], ifid_en [3], ifid_flush [3], idex_flush [3], pipe_en [3];
    logic [1:0] haz [3];
    logic [3:0]  cnt0;
    logic [15:0] cnt1;
    logic [7:0]  cnt2;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard #(.DEPTH(2), .FWD_EN(1), .CNT_W(4)) u0 (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_wsel(id_wsel),
        .id_load(id_load), .redirect(redirect), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .ifid_flush(ifid_flush[0]),
        .idex_flush(idex_flush[0]), .pipe_en(pipe_en[0]), .hazard(haz[0]), .stall_cnt(cnt0));

    hazard_scoreboard #(.DEPTH(2), .FWD_EN(0), .CNT_W(16)) u1 (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_wsel(id_wsel),
        .id_load(id_load), .redirect(redirect), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .ifid_flush(ifid_flush[1]),
        .idex_flush(idex_flush[1]), .pipe_en(pipe_en[1]), .hazard(haz[1]), .stall_cnt(cnt1));

    hazard_scoreboard #(.DEPTH(3), .FWD_EN(0), .CNT_W(8)) u2 (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_wsel(id_wsel),
        .id_load(id_load), .redirect(redirect), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .pc_en(pc_en[2]), .ifid_en(ifid_en[2]), .ifid_flush(ifid_flush[2]),
        .idex_flush(idex_flush[2]), .pipe_en(pipe_en[2]), .hazard(haz[2]), .stall_cnt(cnt2));

    // Reference model: writers are remembered by the pipeline-advance number at
    // which they issued; a writer is visible to ID while its age is below DEPTH.
    int         DP   [3] = '{2, 2, 3};
    bit         FW   [3] = '{1'b1, 1'b0, 1'b0};
    int         CMAX [3] = '{15, 65535, 255};
    bit         m_mw [3], m_rp [3];
    int         m_cnt [3], m_adv [3];
    bit         h_v [3][8], h_l [3][8];
    logic [4:0] h_w [3][8];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mw[i] = 0; m_rp[i] = 0; m_cnt[i] = 0; m_adv[i] = 0;
            for (int a = 0; a < 8; a++) begin
                h_v[i][a] = 0; h_l[i][a] = 0; h_w[i][a] = 5'd0;
            end
        end
    endtask

    task automatic model_eval(input int i, output bit frz, output bit rdr, output bit rw,
                              output logic [6:0] ectl);
        frz = m_mw[i] || (dmem_req && !dhit);
        rdr = !frz && (redirect || m_rp[i]);
        rw  = 0;
        for (int k = 0; k < DP[i]; k++) begin
            int idx;
            idx = (m_adv[i] - 1 - k) & 7;
            if (h_v[i][idx] && h_w[i][idx] != 5'd0 &&
                ((id_use_rs && h_w[i][idx] == id_rs) || (id_use_rt && h_w[i][idx] == id_rt)) &&
                (!FW[i] || (k == 0 && h_l[i][idx])))
                rw = 1;
        end
        rw = rw && id_valid;
        // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, hazard}
        if (frz)        ectl = {5'b00000, 2'd3};
        else if (rdr)   ectl = {5'b10111, 2'd2};
        else if (rw)    ectl = {5'b00011, 2'd1};
        else if (!ihit) ectl = {5'b00101, 2'd0};
        else            ectl = {5'b11001, 2'd0};
    endtask

    function automatic logic [6:0] got_ctl(input int i);
        return {pc_en[i], ifid_en[i], ifid_flush[i], idex_flush[i], pipe_en[i], haz[i]};
    endfunction

    function automatic logic [31:0] got_cnt(input int i);
        case (i)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit frz, rdr, rw;
        logic [6:0] ectl;
        for (int i = 0; i < 3; i++) begin
            model_eval(i, frz, rdr, rw, ectl);
            chk($sformatf("ctl_u%0d", i), 32'(got_ctl(i)), 32'(ectl));
            chk($sformatf("cnt_u%0d", i), got_cnt(i), 32'(m_cnt[i]));
        end
    endtask

    task automatic advance_all();
        bit frz, rdr, rw;
        logic [6:0] ectl;
        for (int i = 0; i < 3; i++) begin
            model_eval(i, frz, rdr, rw, ectl);
            if (!frz) begin
                h_v[i][m_adv[i] & 7] = id_valid && id_wr && !rw && !rdr;
                h_w[i][m_adv[i] & 7] = id_wsel;
                h_l[i][m_adv[i] & 7] = id_load;
                m_adv[i]++;
            end
            if (!frz && !rdr && rw && m_cnt[i] < CMAX[i]) m_cnt[i]++;
            m_mw[i] = m_mw[i] ? !dhit : (dmem_req && !dhit);
            m_rp[i] = frz ? (m_rp[i] || redirect) : 1'b0;
        end
    endtask

    task automatic tick_begin();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic tick_end();
        advance_all();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        tick_begin();
        tick_end();
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic wr,
                          input logic [4:0] ws, input logic ld);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_wr = wr; id_wsel = ws; id_load = ld;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK); #2 nRST = 1'b1;
        @(posedge CLK); #1;

        // Idle after reset
        tick_begin();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_haz_u%0d", i), 32'(haz[i]), 0);
            chk($sformatf("rst_pc_u%0d", i), 32'(pc_en[i] & ifid_en[i] & pipe_en[i]), 1);
        end
        tick_end();

        // LW $2 then reader of $2
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd2, 1);
        tick();
        set_id(1, 5'd2, 1, 5'd0, 0, 0, 5'd0, 0);
        tick_begin();
        chk("lu_haz_u0", 32'(haz[0]), 1);
        chk("lu_pc_u0", 32'(pc_en[0]), 0);
        chk("lu_idexf_u0", 32'(idex_flush[0]), 1);
        tick_end();
        tick_begin();
        chk("lu_after_u0", 32'(haz[0]), 0);
        chk("lu_cnt_u0", got_cnt(0), 1);
        chk("nf_haz2_u1", 32'(haz[1]), 1);
        tick_end();
        tick_begin();
        chk("nf_done_u1", 32'(haz[1]), 0);
        chk("nf_cnt_u1", got_cnt(1), 2);
        chk("d3_haz3_u2", 32'(haz[2]), 1);
        tick_end();
        tick_begin();
        chk("d3_cnt_u2", got_cnt(2), 3);
        tick_end();

        // Writer to $0 then reader of $0
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 1);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0);
        tick_begin();
        for (int i = 0; i < 3; i++) chk($sformatf("r0_haz_u%0d", i), 32'(haz[i]), 0);
        tick_end();

        // Redirect coinciding with load-use; redirected ID never enters scoreboard
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd4, 1);
        tick();
        set_id(1, 5'd4, 1, 5'd0, 0, 0, 5'd0, 0);
        redirect = 1'b1;
        tick_begin();
        chk("rd_haz_u0", 32'(haz[0]), 2);
        chk("rd_flush_u0", 32'({ifid_flush[0], idex_flush[0]}), 3);
        chk("rd_cnt_u0", got_cnt(0), 1);
        tick_end();
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 1);
        tick();
        redirect = 1'b0;
        set_id(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0);
        tick_begin();
        for (int i = 0; i < 3; i++) chk($sformatf("rd_e0_u%0d", i), 32'(haz[i]), 0);
        tick_end();

        // Memory freeze with redirect held across it
        set_id(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);
        dmem_req = 1'b1; dhit = 1'b0;
        for (int c = 0; c < 3; c++) begin
            redirect = (c == 1);
            tick_begin();
            chk($sformatf("mw_haz_c%0d", c), 32'(haz[0]), 3);
            chk($sformatf("mw_pipe_c%0d", c), 32'(pipe_en[0]), 0);
            tick_end();
        end
        redirect = 1'b0; dhit = 1'b1;
        tick();
        dmem_req = 1'b0; dhit = 1'b0;
        tick_begin();
        chk("mw_redir_haz", 32'(haz[0]), 2);
        chk("mw_redir_flush", 32'({ifid_flush[0], idex_flush[0]}), 3);
        tick_end();
        tick_begin();
        chk("mw_normal_haz", 32'(haz[0]), 0);
        tick_end();

        // Self-dependent LW $2,($2): alternate issue/stall until counter saturates
        set_id(1, 5'd2, 1, 5'd0, 0, 1, 5'd2, 1);
        repeat (40) tick();
        tick_begin();
        chk("sat_cnt_u0", got_cnt(0), 15);
        chk("sat_midstall_u1", 32'(haz[1]), 1);
        #1 nRST = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("arst_haz_u%0d", i), 32'(haz[i]), 0);
            chk($sformatf("arst_cnt_u%0d", i), got_cnt(i), 0);
        end
        @(posedge CLK);
        @(negedge CLK); #2 nRST = 1'b1;
        @(posedge CLK); #1;

        // Randomised traffic over a small register set to provoke matches
        for (int n = 0; n < 3000; n++) begin
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            redirect = ($urandom_range(0, 9) == 0);
            dmem_req = ($urandom_range(0, 6) == 0);
            dhit     = 1'($urandom_range(0, 1));
            ihit     = ($urandom_range(0, 4) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised stall/flush controller for the 5-stage MIPS pipeline, sitting beside the ID stage and driving the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latch enables and flushes. Instead of decoding the raw instruction words of later stages, it keeps its own shift-register scoreboard of in-flight register writers and resolves RAW hazards against it, with or without forwarding. It also sequences memory-wait freezes and branch/jump redirects, holding a redirect that arrives during a data-memory wait, and keeps a saturating stall-cycle counter for performance checks.

## Interface
- DEPTH, 2: number of producer stages between ID and register-file write that ID cannot read (entry 0 = EX, entry DEPTH-1 = oldest); legal 1..4
- FWD_EN, 1: 1 = forwarding present, stall only on load-use (entry 0 is a load); 0 = stall on any RAW match in any entry
- CNT_W, 16: width of stall counter

- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5  ID source register numbers
- id_use_rs, id_use_rt  in  1  source actually read
- id_wr  in  1  ID instruction writes a register
- id_wsel  in  5  ID destination register
- id_load  in  1  ID instruction is LW
- redirect  in  1  branch taken / J / JAL / JR resolved this cycle
- ihit  in  1  instruction fetch complete
- dmem_req  in  1  MEM stage has a load/store outstanding
- dhit  in  1  data access complete
- pc_en  out  1  PC may update
- ifid_en, ifid_flush  out  1  IF/ID enable / clear to nop
- idex_flush  out  1  load nop bubble into ID/EX
- pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB
- hazard  out  2  0 none, 1 RAW stall, 2 redirect, 3 memory freeze
- stall_cnt  out  CNT_W  saturating count of RAW-stall cycles

## Operation
- Scoreboard: DEPTH entries {valid, wsel, load}. On every cycle with pipe_en=1 entries shift toward oldest; entry 0 loads {id_valid & id_wr & issue, id_wsel, id_load}, where issue = no RAW stall and no redirect. Stalled or flushed ID inserts an invalid entry.
- Match on entry k: valid & wsel!=0 & ((id_use_rs & wsel==id_rs) | (id_use_rt & wsel==id_rt)). Register 0 never matches.
- raw = id_valid & any match on k where FWD_EN=0, or k=0 & load where FWD_EN=1.
- FSM states RUN, DWAIT. RUN->DWAIT when dmem_req & !dhit; DWAIT->RUN when dhit. DWAIT and the RUN-cycle that triggers it are freeze cycles.
- redir_pend register: set when redirect occurs during a freeze; cleared on the first non-freeze cycle, which is treated as a redirect cycle.
- Priority per cycle: freeze > redirect (redirect | redir_pend) > raw > ifetch miss > none.
  - freeze: pc_en=0, ifid_en=0, pipe_en=0, flushes 0, hazard=3, scoreboard holds.
  - redirect: pc_en=1, ifid_flush=1, idex_flush=1, pipe_en=1, hazard=2; raw ignored, counter not incremented.
  - raw: pc_en=0, ifid_en=0, idex_flush=1, pipe_en=1, hazard=1, stall_cnt +1 (saturates at all-ones).
  - !ihit: pc_en=0, ifid_flush=1, pipe_en=1, hazard=0.
  - none: pc_en=1, ifid_en=1, pipe_en=1, flushes 0, hazard=0.

## Timing
- All control outputs combinational from current inputs and registered state; no added latency.
- Scoreboard, FSM, redir_pend, stall_cnt update on rising CLK.
- Load-use with FWD_EN=1: exactly one stall cycle; dependent instruction issues the next cycle.
- FWD_EN=0: stall lasts until the producer leaves entry DEPTH-1 (at most DEPTH cycles).
- Reset (async, nRST low): scoreboard all invalid, FSM=RUN, redir_pend=0, stall_cnt=0; with idle inputs (ihit=1, others 0) outputs pc_en=1, ifid_en=1, pipe_en=1, flushes 0, hazard=0. Reset mid-stall or mid-DWAIT discards pending hazards and any held redirect.

## Test plan
- FWD_EN=1: LW $2 issues, next ID reads rs=$2 -> one cycle hazard=1, pc_en=0, idex_flush=1, stall_cnt=1; next cycle hazard=0.
- FWD_EN=0, DEPTH=2: ADD $3 issues, next ID reads rt=$3 -> 2 stall cycles, stall_cnt=2.
- Writer to $0 then reader of $0 -> no stall, hazard=0 throughout.
- redirect in the same cycle as a load-use match -> hazard=2, ifid_flush=idex_flush=1, stall_cnt unchanged, entry 0 invalid.
- dmem_req=1, dhit=0 for 3 cycles with redirect pulsed in cycle 2 -> hazard=3, pipe_en=0 for 3 cycles; cycle after dhit: hazard=2, flushes asserted, then normal.
- Saturation with CNT_W=4: 20 raw-stall cycles -> stall_cnt=15; nRST low mid-stall -> stall_cnt=0, hazard=0 immediately.
